// File: rtl/ctl.sv
// Stopwatch control FSM: decodes trig (start/pause) and split (clear-while-paused)
// into Mealy outputs init_regs and count_enabled.
module ctl (
    input  logic clk,
    input  logic reset,
    input  logic trig,
    input  logic split,
    output logic init_regs,
    output logic count_enabled
);

    typedef enum logic [1:0] {
        PAUSED   = 2'd0,
        COUNTING = 2'd1,
        IDLE     = 2'd2
    } state_e;

    // Raw 2-bit register so the unused code 2'd3 stays representable and recoverable.
    logic [1:0] state_q;
    logic [1:0] state_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        init_regs     = 1'b0;
        count_enabled = 1'b0;
        if (reset) begin
            init_regs = 1'b1;
            state_d   = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (trig) begin
                        count_enabled = 1'b1;
                        state_d       = COUNTING;
                    end else begin
                        init_regs = 1'b1;
                    end
                end
                COUNTING: begin
                    if (trig) begin
                        state_d = PAUSED;
                    end else begin
                        count_enabled = 1'b1;
                    end
                end
                PAUSED: begin
                    if (trig) begin
                        count_enabled = 1'b1;
                        state_d       = COUNTING;
                    end else if (split) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    init_regs = 1'b1;
                    state_d   = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ctl.sv
// Directed self-checking bench for the stopwatch control FSM.
module tb_ctl;

    logic clk;
    logic reset;
    logic trig;
    logic split;
    logic init_regs;
    logic count_enabled;

    int unsigned n_tests;
    int unsigned n_fail;

    ctl dut (
        .clk           (clk),
        .reset         (reset),
        .trig          (trig),
        .split         (split),
        .init_regs     (init_regs),
        .count_enabled (count_enabled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs just after a rising edge, then wait to the falling edge to sample.
    task automatic drive(input logic r, input logic t, input logic s);
        reset = r;
        trig  = t;
        split = s;
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [1:0] obs;
        drive(1'b1, 1'b0, 1'b0);
        obs = {init_regs, count_enabled};
        n_tests++;
        if (obs !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_assert: got %b expected 10", obs);
        end
        tick();
        drive(1'b0, 1'b0, 1'b0);
        obs = {init_regs, count_enabled};
        n_tests++;
        if (obs !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_release_idle: got %b expected 10", obs);
        end
        tick();
        drive(1'b1, 1'b0, 1'b0);
        obs = {init_regs, count_enabled};
        n_tests++;
        if (obs !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_in_idle: got %b expected 10", obs);
        end
        tick();
        drive(1'b0, 1'b0, 1'b1);
        obs = {init_regs, count_enabled};
        n_tests++;
        if (obs !== 2'b10) begin
            n_fail++;
            $display("FAIL idle_split_ignored: got %b expected 10", obs);
        end
        tick();
    endtask

    task automatic test_start();
        logic [1:0] obs;
        drive(1'b0, 1'b1, 1'b0);
        obs = {init_regs, count_enabled};
        n_tests++;
        if (obs !== 2'b01) begin
            n_fail++;
            $display("FAIL start_pulse: got %b expected 01", obs);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, (i == 1) ? 1'b1 : 1'b0);
            obs = {init_regs, count_enabled};
            n_tests++;
            if (obs !== 2'b01) begin
                n_fail++;
                $display("FAIL counting_hold[%0d]: got %b expected 01", i, obs);
            end
            tick();
        end
    endtask

    // Entered with the FSM in COUNTING.
    task automatic test_pause();
        logic [1:0] obs;
        drive(1'b0, 1'b1, 1'b0);
        obs = {init_regs, count_enabled};
        n_tests++;
        if (obs !== 2'b00) begin
            n_fail++;
            $display("FAIL pause_pulse: got %b expected 00", obs);
        end
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 1'b0);
            obs = {init_regs, count_enabled};
            n_tests++;
            if (obs !== 2'b00) begin
                n_fail++;
                $display("FAIL paused_hold[%0d]: got %b expected 00", i, obs);
            end
            tick();
        end
        drive(1'b0, 1'b1, 1'b0);
        obs = {init_regs, count_enabled};
        n_tests++;
        if (obs !== 2'b01) begin
            n_fail++;
            $display("FAIL resume_pulse: got %b expected 01", obs);
        end
        tick();
        drive(1'b0, 1'b1, 1'b0);
        obs = {init_regs, count_enabled};
        n_tests++;
        if (obs !== 2'b00) begin
            n_fail++;
            $display("FAIL repause_pulse: got %b expected 00", obs);
        end
        tick();
        drive(1'b0, 1'b0, 1'b1);
        obs = {init_regs, count_enabled};
        n_tests++;
        if (obs !== 2'b00) begin
            n_fail++;
            $display("FAIL split_in_paused: got %b expected 00", obs);
        end
        tick();
        drive(1'b0, 1'b0, 1'b0);
        obs = {init_regs, count_enabled};
        n_tests++;
        if (obs !== 2'b10) begin
            n_fail++;
            $display("FAIL idle_after_split: got %b expected 10", obs);
        end
        tick();
    endtask

    // Entered in IDLE; leaves in IDLE.
    task automatic test_reset_mid();
        logic [1:0] obs;
        drive(1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b0);
        obs = {init_regs, count_enabled};
        n_tests++;
        if (obs !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_in_counting: got %b expected 10", obs);
        end
        tick();
        drive(1'b0, 1'b0, 1'b0);
        obs = {init_regs, count_enabled};
        n_tests++;
        if (obs !== 2'b10) begin
            n_fail++;
            $display("FAIL idle_after_count_reset: got %b expected 10", obs);
        end
        tick();
        drive(1'b0, 1'b1, 1'b0);
        obs = {init_regs, count_enabled};
        n_tests++;
        if (obs !== 2'b01) begin
            n_fail++;
            $display("FAIL restart_after_reset: got %b expected 01", obs);
        end
        tick();
        drive(1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b0);
        obs = {init_regs, count_enabled};
        n_tests++;
        if (obs !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_in_paused: got %b expected 10", obs);
        end
        tick();
        drive(1'b0, 1'b0, 1'b0);
        obs = {init_regs, count_enabled};
        n_tests++;
        if (obs !== 2'b10) begin
            n_fail++;
            $display("FAIL idle_after_pause_reset: got %b expected 10", obs);
        end
        tick();
    endtask

    // Entered in IDLE; leaves in IDLE.
    task automatic test_priority();
        logic [1:0] obs;
        drive(1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b1, 1'b1);
        obs = {init_regs, count_enabled};
        n_tests++;
        if (obs !== 2'b01) begin
            n_fail++;
            $display("FAIL trig_over_split: got %b expected 01", obs);
        end
        tick();
        drive(1'b0, 1'b0, 1'b0);
        obs = {init_regs, count_enabled};
        n_tests++;
        if (obs !== 2'b01) begin
            n_fail++;
            $display("FAIL counting_after_trig_split: got %b expected 01", obs);
        end
        tick();
        drive(1'b1, 1'b1, 1'b0);
        obs = {init_regs, count_enabled};
        n_tests++;
        if (obs !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_over_trig: got %b expected 10", obs);
        end
        tick();
        drive(1'b0, 1'b0, 1'b0);
        obs = {init_regs, count_enabled};
        n_tests++;
        if (obs !== 2'b10) begin
            n_fail++;
            $display("FAIL idle_after_reset_trig: got %b expected 10", obs);
        end
        tick();
    endtask

    // Held trig toggles COUNTING/PAUSED every cycle; entered and left in IDLE.
    task automatic test_back_to_back();
        logic [1:0] obs;
        logic [1:0] exp_seq [4];
        exp_seq = '{2'b01, 2'b00, 2'b01, 2'b00};
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            obs = {init_regs, count_enabled};
            n_tests++;
            if (obs !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL held_trig[%0d]: got %b expected %b", i, obs, exp_seq[i]);
            end
            tick();
        end
        drive(1'b0, 1'b0, 1'b0);
        obs = {init_regs, count_enabled};
        n_tests++;
        if (obs !== 2'b00) begin
            n_fail++;
            $display("FAIL paused_after_held: got %b expected 00", obs);
        end
        tick();
        drive(1'b0, 1'b0, 1'b1);
        tick();
    endtask

    // Entered in IDLE.
    task automatic test_illegal();
        logic [1:0] obs;
        logic [1:0] nxt;
        force dut.state_q = 2'b11;
        drive(1'b0, 1'b1, 1'b1);
        obs = {init_regs, count_enabled};
        nxt = dut.state_d;
        n_tests++;
        if (obs !== 2'b10) begin
            n_fail++;
            $display("FAIL illegal_outputs: got %b expected 10", obs);
        end
        n_tests++;
        if (nxt !== 2'b10) begin
            n_fail++;
            $display("FAIL illegal_next_state: got %b expected 10", nxt);
        end
        release dut.state_q;
        tick();
        drive(1'b0, 1'b1, 1'b0);
        obs = {init_regs, count_enabled};
        n_tests++;
        if (obs !== 2'b01) begin
            n_fail++;
            $display("FAIL idle_after_illegal: got %b expected 01", obs);
        end
        tick();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        trig    = 1'b0;
        split   = 1'b0;
        #1;
        test_reset();
        test_start();
        test_pause();
        test_reset_mid();
        test_priority();
        test_back_to_back();
        test_illegal();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
